conv_ctrl_param: RTL and testbench

CONV_CTRL_PARAM -- requirements
Module: conv_ctrl_param

---
 rtl/conv_ctrl_param.sv | 190 +++++++++++++++++++
 tb/tb_conv_ctrl_param.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/conv_ctrl_param.sv
// Convolution sequencer: loads an image and a filter through a valid/ready
// port, walks every output pixel tap by tap to drive a MAC pipeline, writes
// each pixel's result and then streams the result buffer addresses out.
//
// Handshakes (both directions use the same rule): a word moves on a clk edge
// where valid and ready are both 1. in_ready is high for the whole load
// phase, so in_valid alone qualifies a load word. out_valid stays high in OUT
// and out_addr is held stable until out_ready accepts the current word.
module conv_ctrl_param #(
    parameter int IW  = 4,
    parameter int IH  = 4,
    parameter int K   = 3,
    parameter int S   = 1,
    parameter int CH  = 1,
    parameter int LAT = 2,
    parameter int AW  = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          go,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          img_we,
    output logic          flt_we,
    output logic [AW-1:0] wr_addr,
    output logic [AW-1:0] rd_img_addr,
    output logic [AW-1:0] rd_flt_addr,
    output logic          mac_en,
    output logic          acc_clr,
    output logic          res_we,
    output logic [AW-1:0] res_addr,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] out_addr,
    output logic          busy,
    output logic          done
);

    localparam int OW = (IW - K) / S + 1;
    localparam int OH = (IH - K) / S + 1;
    localparam int NT = K * K * CH;
    localparam int NI = IW * IH * CH;
    localparam int NP = OW * OH;

    // Reject geometries the address walk cannot represent.
    generate
        if (S < 1 || K > IW || K > IH || ((IW - K) % S) != 0 || ((IH - K) % S) != 0 ||
            LAT < 1 || longint'(NI) > (longint'(1) << AW)) begin : g_bad_params
            $fatal(1, "conv_ctrl_param: illegal parameter set");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE, LD_IMG, LD_FLT, CONV, DRAIN, WRES, OUT, FIN
    } state_t;

    // state is the observable FSM state for checkers.
    state_t state, state_nxt;

    logic [31:0] ld_cnt, kx, ky, c, ox, oy, lat_cnt, out_cnt;
    logic        ld_img_last, ld_flt_last, tap_last, pix_last, lat_last, out_last;
    logic [31:0] img_full, flt_full, res_full;

    assign ld_img_last = (ld_cnt == NI - 1);
    assign ld_flt_last = (ld_cnt == NT - 1);
    assign tap_last    = (kx == K - 1) && (ky == K - 1) && (c == CH - 1);
    assign pix_last    = (ox == OW - 1) && (oy == OH - 1);
    assign lat_last    = (lat_cnt == LAT - 1);
    assign out_last    = (out_cnt == NP - 1);

    assign img_full = (c * IH + oy * S + ky) * IW + ox * S + kx;
    assign flt_full = (c * K + ky) * K + kx;
    assign res_full = oy * OW + ox;

    // State register; reset aborts any operation in progress.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next-state decode; go only matters in IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (go) state_nxt = LD_IMG;
            LD_IMG:  if (in_valid && ld_img_last) state_nxt = LD_FLT;
            LD_FLT:  if (in_valid && ld_flt_last) state_nxt = CONV;
            CONV:    if (tap_last) state_nxt = DRAIN;
            DRAIN:   if (lat_last) state_nxt = WRES;
            WRES:    state_nxt = pix_last ? OUT : CONV;
            OUT:     if (out_ready && out_last) state_nxt = FIN;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Load, tap, pixel, latency and stream counters; each wraps to 0 on exit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ld_cnt  <= '0;
            kx      <= '0;
            ky      <= '0;
            c       <= '0;
            ox      <= '0;
            oy      <= '0;
            lat_cnt <= '0;
            out_cnt <= '0;
        end else begin
            case (state)
                LD_IMG: if (in_valid) ld_cnt <= ld_img_last ? '0 : ld_cnt + 1;
                LD_FLT: if (in_valid) ld_cnt <= ld_flt_last ? '0 : ld_cnt + 1;
                CONV: begin
                    if (kx != K - 1) begin
                        kx <= kx + 1;
                    end else begin
                        kx <= '0;
                        if (ky != K - 1) begin
                            ky <= ky + 1;
                        end else begin
                            ky <= '0;
                            c  <= (c == CH - 1) ? '0 : c + 1;
                        end
                    end
                end
                DRAIN: lat_cnt <= lat_last ? '0 : lat_cnt + 1;
                WRES: begin
                    if (ox != OW - 1) begin
                        ox <= ox + 1;
                    end else begin
                        ox <= '0;
                        oy <= (oy == OH - 1) ? '0 : oy + 1;
                    end
                end
                OUT: if (out_ready) out_cnt <= out_last ? '0 : out_cnt + 1;
                default: begin
                    ld_cnt  <= '0;
                    lat_cnt <= '0;
                    out_cnt <= '0;
                end
            endcase
        end
    end

    // Output decode from registered state/counters; load strobes follow in_valid.
    always_comb begin
        in_ready    = 1'b0;
        img_we      = 1'b0;
        flt_we      = 1'b0;
        wr_addr     = '0;
        rd_img_addr = '0;
        rd_flt_addr = '0;
        mac_en      = 1'b0;
        acc_clr     = 1'b0;
        res_we      = 1'b0;
        res_addr    = '0;
        out_valid   = 1'b0;
        out_addr    = '0;
        busy        = (state != IDLE);
        done        = 1'b0;
        case (state)
            LD_IMG: begin
                in_ready = 1'b1;
                img_we   = in_valid;
                wr_addr  = AW'(ld_cnt);
            end
            LD_FLT: begin
                in_ready = 1'b1;
                flt_we   = in_valid;
                wr_addr  = AW'(ld_cnt);
            end
            CONV: begin
                mac_en      = 1'b1;
                acc_clr     = (kx == 0) && (ky == 0) && (c == 0);
                rd_img_addr = AW'(img_full);
                rd_flt_addr = AW'(flt_full);
            end
            WRES: begin
                res_we   = 1'b1;
                res_addr = AW'(res_full);
            end
            OUT: begin
                out_valid = 1'b1;
                out_addr  = AW'(out_cnt);
            end
            FIN:     done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_conv_ctrl_param.sv
// Directed bench for conv_ctrl_param: a default 4x4 instance and a 5x5
// stride-2 instance share all inputs; one is observed at a time.
module tb_conv_ctrl_param;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic go = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b1;
    int   sel = 0;

    logic       a_in_ready, a_img_we, a_flt_we, a_mac_en, a_acc_clr, a_res_we, a_out_valid, a_busy, a_done;
    logic [7:0] a_wr_addr, a_rd_img_addr, a_rd_flt_addr, a_res_addr, a_out_addr;
    logic       b_in_ready, b_img_we, b_flt_we, b_mac_en, b_acc_clr, b_res_we, b_out_valid, b_busy, b_done;
    logic [7:0] b_wr_addr, b_rd_img_addr, b_rd_flt_addr, b_res_addr, b_out_addr;

    logic       m_in_ready, m_img_we, m_flt_we, m_mac_en, m_acc_clr, m_res_we, m_out_valid, m_busy, m_done;
    logic [7:0] m_wr_addr, m_rd_img_addr, m_rd_flt_addr, m_res_addr, m_out_addr;
    logic [50:0] m_outs;

    int total = 0;
    int bad = 0;
    logic [7:0] exp_q[$];
    int tap0 [2][4] = '{'{0, 1, 4, 5}, '{0, 2, 10, 12}};

    conv_ctrl_param dut_a (
        .clk(clk), .rst(rst), .go(go), .in_valid(in_valid), .in_ready(a_in_ready),
        .img_we(a_img_we), .flt_we(a_flt_we), .wr_addr(a_wr_addr),
        .rd_img_addr(a_rd_img_addr), .rd_flt_addr(a_rd_flt_addr),
        .mac_en(a_mac_en), .acc_clr(a_acc_clr), .res_we(a_res_we), .res_addr(a_res_addr),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_addr(a_out_addr),
        .busy(a_busy), .done(a_done)
    );

    conv_ctrl_param #(.IW(5), .IH(5), .S(2)) dut_b (
        .clk(clk), .rst(rst), .go(go), .in_valid(in_valid), .in_ready(b_in_ready),
        .img_we(b_img_we), .flt_we(b_flt_we), .wr_addr(b_wr_addr),
        .rd_img_addr(b_rd_img_addr), .rd_flt_addr(b_rd_flt_addr),
        .mac_en(b_mac_en), .acc_clr(b_acc_clr), .res_we(b_res_we), .res_addr(b_res_addr),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_addr(b_out_addr),
        .busy(b_busy), .done(b_done)
    );

    // Observe the selected instance.
    always_comb begin
        if (sel == 1) begin
            {m_in_ready, m_img_we, m_flt_we, m_mac_en, m_acc_clr, m_res_we, m_out_valid, m_busy, m_done} =
                {b_in_ready, b_img_we, b_flt_we, b_mac_en, b_acc_clr, b_res_we, b_out_valid, b_busy, b_done};
            {m_wr_addr, m_rd_img_addr, m_rd_flt_addr, m_res_addr, m_out_addr} =
                {b_wr_addr, b_rd_img_addr, b_rd_flt_addr, b_res_addr, b_out_addr};
        end else begin
            {m_in_ready, m_img_we, m_flt_we, m_mac_en, m_acc_clr, m_res_we, m_out_valid, m_busy, m_done} =
                {a_in_ready, a_img_we, a_flt_we, a_mac_en, a_acc_clr, a_res_we, a_out_valid, a_busy, a_done};
            {m_wr_addr, m_rd_img_addr, m_rd_flt_addr, m_res_addr, m_out_addr} =
                {a_wr_addr, a_rd_img_addr, a_rd_flt_addr, a_res_addr, a_out_addr};
        end
        m_outs = {m_in_ready, m_img_we, m_flt_we, m_wr_addr, m_rd_img_addr, m_rd_flt_addr,
                  m_mac_en, m_acc_clr, m_res_we, m_res_addr, m_out_valid, m_out_addr, m_busy, m_done};
    end

    // Clock.
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        if (obs !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        go = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    // Full operation: vmode 0 = continuous in_valid, 1 = low on even cycles.
    // stall_at >= 0 drops out_ready for 3 cycles when out_addr reaches it.
    task automatic run_op(input int dsel, input int vmode, input int stall_at,
                          input int ni, input int exp_load);
        int cyc, img_cnt, flt_cnt, mac_cnt, acc_idx, res_idx, out_idx, done_cnt, stall_cnt;
        int conv_start, after;
        cyc = 0; img_cnt = 0; flt_cnt = 0; mac_cnt = 0; acc_idx = 0; res_idx = 0;
        out_idx = 0; done_cnt = 0; stall_cnt = 0; conv_start = -1; after = -1;
        sel = dsel;
        do_reset();
        exp_q.delete();
        for (int p = 0; p < 4; p++) exp_q.push_back(8'(p));
        @(negedge clk);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        while (cyc < 3000) begin
            in_valid = (vmode == 0) ? 1'b1 : 1'((cyc % 2) == 1);
            out_ready = 1'b1;
            if (m_out_valid && stall_at >= 0 && int'(m_out_addr) == stall_at && stall_cnt < 3) begin
                out_ready = 1'b0;
                stall_cnt++;
            end
            #1;
            if (m_in_ready) begin
                if (img_cnt < ni) check("ld_img_addr", m_wr_addr, img_cnt);
                else check("ld_flt_addr", m_wr_addr, flt_cnt);
            end
            if (m_img_we) img_cnt++;
            if (m_flt_we) flt_cnt++;
            if (m_mac_en) begin
                if (conv_start < 0) begin
                    conv_start = cyc;
                    check("load_cycles", cyc, exp_load);
                end
                mac_cnt++;
            end
            if (m_acc_clr) begin
                check("acc_clr_cycle", cyc, conv_start + 12 * acc_idx);
                if (acc_idx < 4) check("tap0_img_addr", m_rd_img_addr, tap0[dsel][acc_idx]);
                acc_idx++;
            end
            if (m_res_we) begin
                if (exp_q.size() == 0) begin
                    check("res_extra", 1, 0);
                end else begin
                    check("res_addr", m_res_addr, exp_q.pop_front());
                    check("res_cycle", cyc, conv_start + 12 * res_idx + 11);
                end
                res_idx++;
            end
            if (m_out_valid && !out_ready) check("stall_addr", m_out_addr, stall_at);
            if (m_out_valid && out_ready) begin
                check("out_addr", m_out_addr, out_idx);
                out_idx++;
            end
            if (m_done) begin
                done_cnt++;
                if (after < 0) after = cyc;
            end
            if (after >= 0 && cyc == after + 3) break;
            @(negedge clk);
            cyc++;
        end
        if (after < 0) check("timeout", 0, 1);
        check("img_words", img_cnt, ni);
        check("flt_words", flt_cnt, 9);
        check("mac_cycles", mac_cnt, 36);
        check("acc_clr_count", acc_idx, 4);
        check("res_count", res_idx, 4);
        check("out_count", out_idx, 4);
        check("done_count", done_cnt, 1);
        check("stall_cycles", stall_cnt, (stall_at >= 0) ? 3 : 0);
        check("busy_after", m_busy, 0);
    endtask

    // Abort in CONV tap 4 after a stray go at tap 2, then restart.
    task automatic abort_test();
        int cyc, seen;
        logic found;
        cyc = 0; seen = 0; found = 1'b0;
        sel = 0;
        do_reset();
        @(negedge clk);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        in_valid = 1'b1;
        while (cyc < 200) begin
            #1;
            if (m_mac_en && m_rd_flt_addr == 8'd2) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
            cyc++;
        end
        check("reach_tap2", found, 1);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        #1;
        check("go_ignored_tap3", m_rd_flt_addr, 3);
        check("go_ignored_busy", {m_busy, m_mac_en, m_in_ready}, 3'b110);
        @(negedge clk);
        #1;
        check("tap4_addr", m_rd_flt_addr, 4);
        rst = 1'b0;
        #1;
        check("abort_outs_zero", m_outs, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            #1;
            if (m_res_we || m_done || m_busy) seen++;
        end
        check("no_activity_after_abort", seen, 0);
        @(negedge clk);
        in_valid = 1'b0;
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        in_valid = 1'b1;
        #1;
        check("restart_state", {m_busy, m_in_ready, m_img_we}, 3'b111);
        check("restart_addr0", m_wr_addr, 0);
        @(negedge clk);
        #1;
        check("restart_addr1", m_wr_addr, 1);
        do_reset();
    endtask

    initial begin
        rst = 1'b0;
        go = 1'b1;
        in_valid = 1'b1;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        sel = 0;
        #1;
        check("reset_outs_a", m_outs, 0);
        sel = 1;
        #1;
        check("reset_outs_b", m_outs, 0);
        run_op(0, 0, -1, 16, 25);
        run_op(0, 1, 2, 16, 50);
        run_op(1, 0, -1, 25, 34);
        abort_test();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
